// File: rtl/fir_filter_gd_sequencer.sv
// Tap sequencer in front of the FIR gd/ms pipeline register: stores sample history and
// coefficients, then replays NUM_TAPS (x[n-k], h[k]) pairs per accepted sample.
module fir_filter_gd_sequencer #(
    parameter int INPUT_WIDTH = 32,
    parameter int NUM_TAPS    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze,
    input  logic                        flush,
    input  logic [INPUT_WIDTH-1:0]      sample_in,
    input  logic                        sample_valid_in,
    output logic                        sample_ready_out,
    input  logic                        coeff_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0] coeff_wr_addr,
    input  logic [INPUT_WIDTH-1:0]      coeff_wr_data,
    output logic                        coeff_wr_ready,
    output logic [INPUT_WIDTH-1:0]      fir_input_out,
    output logic [INPUT_WIDTH-1:0]      coeff_data_out,
    output logic                        overwrite_out,
    output logic                        output_valid_out,
    output logic                        busy_out
);

    localparam int            AW       = $clog2(NUM_TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [INPUT_WIDTH-1:0] r_history [NUM_TAPS];
    logic [INPUT_WIDTH-1:0] r_coeff   [NUM_TAPS];
    logic [AW-1:0]          r_tap;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW-1:0]          r_wr_ptr;

    logic [INPUT_WIDTH-1:0] r_fir_input;
    logic [INPUT_WIDTH-1:0] r_coeff_data;
    logic                   r_overwrite;
    logic                   r_output_valid;

    logic                   w_idle_open;
    logic                   w_accept;
    logic                   w_coeff_we;
    logic                   w_step;
    logic                   w_addr_ok;

    // Only matters when NUM_TAPS is not a power of two: writes past the table are dropped.
    assign w_addr_ok = ({1'b0, coeff_wr_addr} < (AW + 1)'(NUM_TAPS));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_idle_open      = rst && (r_state == IDLE) && !freeze && !flush;
        coeff_wr_ready   = w_idle_open;
        sample_ready_out = w_idle_open && !coeff_wr_en;
        w_coeff_we       = w_idle_open && coeff_wr_en && w_addr_ok;
        w_accept         = sample_valid_in && w_idle_open && !coeff_wr_en;
        w_step           = 1'b0;
        w_next_state     = r_state;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (!freeze) begin
                    w_step = 1'b1;
                    if (r_tap == LAST_TAP) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: both tables are reset because the filter must see zero history after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_history[i] <= '0;
                r_coeff[i]   <= '0;
            end
            r_tap          <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_fir_input    <= '0;
            r_coeff_data   <= '0;
            r_overwrite    <= 1'b0;
            r_output_valid <= 1'b0;
        end else if (flush) begin
            r_tap          <= '0;
            r_rd_ptr       <= '0;
            r_fir_input    <= '0;
            r_coeff_data   <= '0;
            r_overwrite    <= 1'b0;
            r_output_valid <= 1'b0;
        end else if (!freeze) begin
            if (w_step) begin
                r_fir_input    <= r_history[r_rd_ptr];
                r_coeff_data   <= r_coeff[r_tap];
                r_overwrite    <= (r_tap == '0);
                r_output_valid <= (r_tap == LAST_TAP);
                r_rd_ptr       <= (r_rd_ptr == '0) ? LAST_TAP : r_rd_ptr - 1'b1;
                r_tap          <= (r_tap == LAST_TAP) ? '0 : r_tap + 1'b1;
            end else begin
                r_fir_input    <= '0;
                r_coeff_data   <= '0;
                r_overwrite    <= 1'b0;
                r_output_valid <= 1'b0;
            end

            // Newest sample sits at the old write pointer; reading walks backwards in time.
            if (w_accept) begin
                r_history[r_wr_ptr] <= sample_in;
                r_rd_ptr            <= r_wr_ptr;
                r_wr_ptr            <= (r_wr_ptr == LAST_TAP) ? '0 : r_wr_ptr + 1'b1;
                r_tap               <= '0;
            end

            if (w_coeff_we) begin
                r_coeff[coeff_wr_addr] <= coeff_wr_data;
            end
        end
    end

    assign fir_input_out    = r_fir_input;
    assign coeff_data_out   = r_coeff_data;
    assign overwrite_out    = r_overwrite;
    assign output_valid_out = r_output_valid;
    assign busy_out         = (r_state == RUN);

endmodule

// File: tb/tb_fir_filter_gd_sequencer.sv
// Bench for fir_filter_gd_sequencer: an 8-tap and a 5-tap instance share stimulus through
// a select; a queue-based history/coefficient model predicts every tap.
module tb_fir_filter_gd_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sel;
    logic         d_freeze, d_flush, d_valid, d_we;
    logic [W-1:0] d_x, d_data;
    logic [2:0]   d_addr;

    logic         sr8, cr8, ow8, ov8, bz8;
    logic [W-1:0] x8, h8;
    logic         sr5, cr5, ow5, ov5, bz5;
    logic [W-1:0] x5, h5;

    fir_filter_gd_sequencer #(.INPUT_WIDTH(W), .NUM_TAPS(8)) u8 (
        .clk              (clk),
        .rst              (rst_n),
        .freeze           (d_freeze & ~sel),
        .flush            (d_flush & ~sel),
        .sample_in        (d_x),
        .sample_valid_in  (d_valid & ~sel),
        .sample_ready_out (sr8),
        .coeff_wr_en      (d_we & ~sel),
        .coeff_wr_addr    (d_addr),
        .coeff_wr_data    (d_data),
        .coeff_wr_ready   (cr8),
        .fir_input_out    (x8),
        .coeff_data_out   (h8),
        .overwrite_out    (ow8),
        .output_valid_out (ov8),
        .busy_out         (bz8)
    );

    fir_filter_gd_sequencer #(.INPUT_WIDTH(W), .NUM_TAPS(5)) u5 (
        .clk              (clk),
        .rst              (rst_n),
        .freeze           (d_freeze & sel),
        .flush            (d_flush & sel),
        .sample_in        (d_x),
        .sample_valid_in  (d_valid & sel),
        .sample_ready_out (sr5),
        .coeff_wr_en      (d_we & sel),
        .coeff_wr_addr    (d_addr),
        .coeff_wr_data    (d_data),
        .coeff_wr_ready   (cr5),
        .fir_input_out    (x5),
        .coeff_data_out   (h5),
        .overwrite_out    (ow5),
        .output_valid_out (ov5),
        .busy_out         (bz5)
    );

    wire         o_sr = sel ? sr5 : sr8;
    wire         o_cr = sel ? cr5 : cr8;
    wire         o_ow = sel ? ow5 : ow8;
    wire         o_ov = sel ? ov5 : ov8;
    wire         o_bz = sel ? bz5 : bz8;
    wire [W-1:0] o_x  = sel ? x5 : x8;
    wire [W-1:0] o_h  = sel ? h5 : h8;

    // Reference model: every accepted sample since reset, plus the coefficient table.
    logic [W-1:0] hq[$];
    logic [W-1:0] coef[8];
    int           n_vec = 0;
    int           n_err = 0;
    time          last_ov_time;

    typedef struct packed {
        logic frz, fl, we, val, exp_sr, exp_cr;
    } hs_vec_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] mac;
    } imp_vec_t;

    hs_vec_t  hs_tab[6];
    imp_vec_t imp_tab[8];

    function automatic int cur_n();
        return sel ? 5 : 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_x"},  o_x, '0);
        check({tag, "_h"},  o_h, '0);
        check({tag, "_ow"}, 32'(o_ow), 32'(0));
        check({tag, "_ov"}, 32'(o_ov), 32'(0));
    endtask

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < 8; i++) coef[i] = '0;
    endtask

    task automatic write_coeff(input logic [2:0] addr, input logic [W-1:0] data);
        d_we   = 1'b1;
        d_addr = addr;
        d_data = data;
        #1;
        check("wr_cready", 32'(o_cr), 32'(1));
        check("wr_sready", 32'(o_sr), 32'(0));
        tick();
        d_we = 1'b0;
        if (int'(addr) < cur_n()) coef[addr] = data;
        check("wr_busy", 32'(o_bz), 32'(0));
    endtask

    // One sample through the sequencer, optionally freezing, flushing or writing coeffs.
    // Starts and ends with the DUT idle; ends right after the last tap is presented.
    task automatic run_sample(input logic [W-1:0] x, input int frz_at, input int frz_len,
                              input int flush_at, input bit wr_during, output logic [W-1:0] mac);
        int           n;
        logic [W-1:0] ex, eh;
        n   = cur_n();
        mac = '0;
        d_x     = x;
        d_valid = 1'b1;
        #1;
        check("acc_sready", 32'(o_sr), 32'(1));
        check("acc_busy", 32'(o_bz), 32'(0));
        tick();
        d_valid = 1'b0;
        d_x     = $urandom;
        hq.push_back(x);
        check_bubble("acc");
        check("run_busy", 32'(o_bz), 32'(1));
        if (wr_during) begin
            d_we   = 1'b1;
            d_addr = 3'($urandom_range(0, n - 1));
            d_data = $urandom;
        end
        #1;
        check("run_sready", 32'(o_sr), 32'(0));
        check("run_cready", 32'(o_cr), 32'(0));
        for (int k = 0; k < n; k++) begin
            tick();
            ex = (hq.size() > k) ? hq[hq.size() - 1 - k] : '0;
            eh = coef[k];
            check($sformatf("tap%0d_x", k), o_x, ex);
            check($sformatf("tap%0d_h", k), o_h, eh);
            check($sformatf("tap%0d_ow", k), 32'(o_ow), 32'(k == 0));
            check($sformatf("tap%0d_ov", k), 32'(o_ov), 32'(k == n - 1));
            check($sformatf("tap%0d_busy", k), 32'(o_bz), 32'(k != n - 1));
            mac = mac + o_x * o_h;
            if (o_ov) last_ov_time = $time;
            if (k == frz_at) begin
                d_freeze = 1'b1;
                for (int j = 0; j < frz_len; j++) begin
                    tick();
                    check($sformatf("frz%0d_x", k), o_x, ex);
                    check($sformatf("frz%0d_h", k), o_h, eh);
                    check($sformatf("frz%0d_ov", k), 32'(o_ov), 32'(k == n - 1));
                    check($sformatf("frz%0d_busy", k), 32'(o_bz), 32'(k != n - 1));
                    check("frz_sready", 32'(o_sr), 32'(0));
                    check("frz_cready", 32'(o_cr), 32'(0));
                end
                d_freeze = 1'b0;
            end
            if (k == flush_at && k < n - 1) begin
                d_flush = 1'b1;
                tick();
                d_flush = 1'b0;
                d_we    = 1'b0;
                #1;
                check_bubble("flush");
                check("flush_busy", 32'(o_bz), 32'(0));
                check("flush_sready", 32'(o_sr), 32'(1));
                return;
            end
        end
        d_we = 1'b0;
        #1;
        check("end_sready", 32'(o_sr), 32'(1));
    endtask

    // One idle edge, then a frozen edge with a sample offered that must not be taken.
    task automatic idle_freeze();
        tick();
        check_bubble("idle");
        d_freeze = 1'b1;
        d_valid  = 1'b1;
        d_x      = $urandom;
        #1;
        check("ifrz_sready", 32'(o_sr), 32'(0));
        check("ifrz_cready", 32'(o_cr), 32'(0));
        tick();
        d_freeze = 1'b0;
        d_valid  = 1'b0;
        check_bubble("ifrz");
        check("ifrz_busy", 32'(o_bz), 32'(0));
    endtask

    task automatic random_ops(input int count);
        logic [W-1:0] mac;
        int           r, fa, fl;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                write_coeff(3'($urandom_range(0, 7)), $urandom);
            end else if (r == 1) begin
                idle_freeze();
            end else begin
                fa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cur_n() - 1) : -1;
                fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, cur_n() - 2) : -1;
                run_sample($urandom, fa, $urandom_range(1, 3), fl, $urandom_range(0, 3) == 0, mac);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mac;
        time          prev_ov;

        hs_tab[0] = '{frz: 0, fl: 0, we: 0, val: 0, exp_sr: 1, exp_cr: 1};
        hs_tab[1] = '{frz: 0, fl: 0, we: 0, val: 1, exp_sr: 1, exp_cr: 1};
        hs_tab[2] = '{frz: 0, fl: 0, we: 1, val: 1, exp_sr: 0, exp_cr: 1};
        hs_tab[3] = '{frz: 0, fl: 0, we: 1, val: 0, exp_sr: 0, exp_cr: 1};
        hs_tab[4] = '{frz: 1, fl: 0, we: 0, val: 1, exp_sr: 0, exp_cr: 0};
        hs_tab[5] = '{frz: 1, fl: 0, we: 1, val: 1, exp_sr: 0, exp_cr: 0};
        imp_tab[0] = '{x: 32'd1, mac: 32'd1};
        for (int i = 1; i < 8; i++) imp_tab[i] = '{x: 32'd0, mac: W'(i + 1)};

        sel = 1'b0; rst_n = 1'b0;
        d_freeze = 1'b0; d_flush = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        d_x = '0; d_data = '0; d_addr = '0;
        model_reset();

        #3;
        check_bubble("rst");
        check("rst_busy", 32'(o_bz), 32'(0));
        check("rst_sready", 32'(o_sr), 32'(0));
        check("rst_cready", 32'(o_cr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_sready", 32'(o_sr), 32'(1));
        check("post_rst_busy", 32'(o_bz), 32'(0));

        // Combinational handshake in IDLE; inputs are cleared before each edge.
        for (int i = 0; i < 6; i++) begin
            tick();
            d_freeze = hs_tab[i].frz; d_flush = hs_tab[i].fl;
            d_we = hs_tab[i].we; d_valid = hs_tab[i].val; d_addr = 3'd7;
            #1;
            check($sformatf("hs%0d_sready", i), 32'(o_sr), 32'(hs_tab[i].exp_sr));
            check($sformatf("hs%0d_cready", i), 32'(o_cr), 32'(hs_tab[i].exp_cr));
            check($sformatf("hs%0d_busy", i), 32'(o_bz), 32'(0));
            d_freeze = 1'b0; d_flush = 1'b0; d_we = 1'b0; d_valid = 1'b0;
        end

        // Impulse response: h = 1..8, back-to-back samples 9 cycles apart.
        for (int i = 0; i < 8; i++) write_coeff(3'(i), W'(i + 1));
        prev_ov = 0;
        for (int i = 0; i < 8; i++) begin
            run_sample(imp_tab[i].x, -1, 0, -1, 1'b0, mac);
            check($sformatf("imp%0d_mac", i), mac, imp_tab[i].mac);
            if (i > 0) check("imp_ov_spacing", 32'(last_ov_time - prev_ov), 32'd90);
            prev_ov = last_ov_time;
        end

        // Freeze at tap 3 for three cycles, then flush at tap 2 and re-run.
        run_sample(32'hABCD, 3, 3, -1, 1'b0, mac);
        run_sample(32'h1234, -1, 0, 2, 1'b0, mac);
        run_sample(32'h5678, -1, 0, -1, 1'b0, mac);

        // Coeff write while running is ignored; write beside a valid sample wins the cycle.
        run_sample(32'h0F0F, -1, 0, -1, 1'b1, mac);
        d_x = 32'h7777; d_valid = 1'b1; d_we = 1'b1; d_addr = 3'd2; d_data = 32'hC0FFEE;
        #1;
        check("both_sready", 32'(o_sr), 32'(0));
        check("both_cready", 32'(o_cr), 32'(1));
        tick();
        d_we = 1'b0;
        coef[2] = 32'hC0FFEE;
        check_bubble("both");
        check("both_busy", 32'(o_bz), 32'(0));
        run_sample(32'h7777, -1, 0, -1, 1'b0, mac);

        // Reset in the middle of a run clears history and coefficients at once.
        d_x = 32'h9999; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_bubble("mid_rst");
        check("mid_rst_busy", 32'(o_bz), 32'(0));
        check("mid_rst_sready", 32'(o_sr), 32'(0));
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        check("mid_rst_rel_sready", 32'(o_sr), 32'(1));
        check("mid_rst_rel_busy", 32'(o_bz), 32'(0));
        run_sample(32'h4242, -1, 0, -1, 1'b0, mac);
        for (int i = 0; i < 8; i++) write_coeff(3'(i), $urandom);

        random_ops(40);

        // Five-tap instance: wrap of a non-power-of-two history.
        rst_n = 1'b0;
        #1;
        sel = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) write_coeff(3'(i), W'(101 + i));
        for (int i = 1; i <= 7; i++) run_sample(W'(10 * i), -1, 0, -1, 1'b0, mac);
        check("wrap5_mac", mac, 32'd25650);

        random_ops(30);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
